// File: rtl/alarm_bank.sv
// Multi-slot hh:mm alarm engine driving one shared buzzer with ring timeout and snooze.
// Optional per-slot weekday masks are enabled by defining ALARM_WEEKDAY_EN.
module alarm_bank #(
   parameter int unsigned NUM_ALARMS = 4,
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned MAX_SNOOZE = 3,
   localparam int unsigned IW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_sec_tick,
   input  logic [5:0]    i_cur_hr,
   input  logic [5:0]    i_cur_min,
   input  logic [5:0]    i_cur_sec,
   input  logic          i_wr_en,
   input  logic [IW-1:0] i_wr_idx,
   input  logic [5:0]    i_wr_hr,
   input  logic [5:0]    i_wr_min,
   input  logic          i_wr_arm,
   input  logic          i_stop_btn,
   input  logic          i_snooze_btn,
`ifdef ALARM_WEEKDAY_EN
   input  logic [6:0]    i_wr_days,
   input  logic [2:0]    i_cur_wday,
`endif
   output logic          o_buzzer,
   output logic [IW-1:0] o_active_idx,
   output logic [1:0]    o_state,
   output logic [11:0]   o_snooze_left,
   output logic          o_wr_err
);

   typedef enum logic [1:0] {StIdle = 2'd0, StRing = 2'd1, StSnooze = 2'd2} state_e;

   localparam logic [7:0]  RingLast   = 8'(RING_SEC - 1);
   localparam logic [7:0]  MaxSnooze  = 8'(MAX_SNOOZE);
   localparam logic [11:0] SnoozeLoad = 12'(SNOOZE_MIN * 60);

   logic [5:0]    r_hr  [NUM_ALARMS];
   logic [5:0]    r_min [NUM_ALARMS];
   logic          r_arm [NUM_ALARMS];
`ifdef ALARM_WEEKDAY_EN
   logic [6:0]    r_days [NUM_ALARMS];
`endif
   state_e        r_state,       w_state_d;
   logic [IW-1:0] r_active_idx,  w_active_idx_d;
   logic [7:0]    r_ring_cnt,    w_ring_cnt_d;
   logic [7:0]    r_snooze_cnt,  w_snooze_cnt_d;
   logic [11:0]   r_snooze_left, w_snooze_left_d;
   logic          r_wr_err;
   logic          r_stop_prev;
   logic          r_snooze_prev;

   logic          w_stop_edge;
   logic          w_snooze_edge;
   logic          w_wr_ok;
   logic          w_cancel;
   logic          w_hit;
   logic [IW-1:0] w_win;

   assign w_stop_edge   = i_stop_btn & ~r_stop_prev;
   assign w_snooze_edge = i_snooze_btn & ~r_snooze_prev;

`ifdef ALARM_WEEKDAY_EN
   assign w_wr_ok = i_wr_en && (32'(i_wr_idx) < NUM_ALARMS) && (i_wr_hr <= 6'd23) &&
                    (i_wr_min <= 6'd59) && (i_wr_days != 7'd0);
`else
   assign w_wr_ok = i_wr_en && (32'(i_wr_idx) < NUM_ALARMS) && (i_wr_hr <= 6'd23) &&
                    (i_wr_min <= 6'd59);
`endif

   // Writing the slot that is currently sounding or snoozing cancels that alarm.
   assign w_cancel = w_wr_ok && (i_wr_idx == r_active_idx) && (r_state != StIdle);

   // Scan downward so the lowest matching index is the one left in w_win.
   always_comb begin
      w_hit = 1'b0;
      w_win = '0;
      for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
         if (i_sec_tick && (i_cur_sec == 6'd0) && r_arm[i] && (r_hr[i] == i_cur_hr) &&
`ifdef ALARM_WEEKDAY_EN
             (i_cur_wday <= 3'd6) && r_days[i][i_cur_wday] &&
`endif
             (r_min[i] == i_cur_min)) begin
            w_hit = 1'b1;
            w_win = IW'(i);
         end
      end
   end

   always_comb begin
      w_state_d       = r_state;
      w_active_idx_d  = r_active_idx;
      w_ring_cnt_d    = r_ring_cnt;
      w_snooze_cnt_d  = r_snooze_cnt;
      w_snooze_left_d = r_snooze_left;
      unique case (r_state)
         StIdle: begin
            if (w_hit && !w_stop_edge) begin
               w_state_d      = StRing;
               w_active_idx_d = w_win;
               w_ring_cnt_d   = '0;
               w_snooze_cnt_d = '0;
            end
         end
         StRing: begin
            if (w_cancel || w_stop_edge) begin
               w_state_d = StIdle;
            end else if (w_snooze_edge) begin
               if (r_snooze_cnt < MaxSnooze) begin
                  w_state_d       = StSnooze;
                  w_snooze_left_d = SnoozeLoad;
                  w_snooze_cnt_d  = r_snooze_cnt + 8'd1;
               end else begin
                  w_state_d = StIdle;
               end
            end else if (i_sec_tick) begin
               if (r_ring_cnt == RingLast) w_state_d = StIdle;
               else                        w_ring_cnt_d = r_ring_cnt + 8'd1;
            end
         end
         StSnooze: begin
            if (w_cancel || w_stop_edge) begin
               w_state_d = StIdle;
            end else if (i_sec_tick) begin
               w_snooze_left_d = r_snooze_left - 12'd1;
               if (r_snooze_left == 12'd1) begin
                  w_state_d    = StRing;
                  w_ring_cnt_d = '0;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
      if (w_state_d == StIdle) begin
         w_ring_cnt_d    = '0;
         w_snooze_cnt_d  = '0;
         w_snooze_left_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            r_hr[i]   <= '0;
            r_min[i]  <= '0;
            r_arm[i]  <= 1'b0;
`ifdef ALARM_WEEKDAY_EN
            r_days[i] <= 7'h7F;
`endif
         end
         r_state       <= StIdle;
         r_active_idx  <= '0;
         r_ring_cnt    <= '0;
         r_snooze_cnt  <= '0;
         r_snooze_left <= '0;
         r_wr_err      <= 1'b0;
         r_stop_prev   <= 1'b0;
         r_snooze_prev <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if (w_wr_ok && (i_wr_idx == IW'(i))) begin
               r_hr[i]   <= i_wr_hr;
               r_min[i]  <= i_wr_min;
               r_arm[i]  <= i_wr_arm;
`ifdef ALARM_WEEKDAY_EN
               r_days[i] <= i_wr_days;
`endif
            end
         end
         r_state       <= w_state_d;
         r_active_idx  <= w_active_idx_d;
         r_ring_cnt    <= w_ring_cnt_d;
         r_snooze_cnt  <= w_snooze_cnt_d;
         r_snooze_left <= w_snooze_left_d;
         r_wr_err      <= i_wr_en & ~w_wr_ok;
         r_stop_prev   <= i_stop_btn;
         r_snooze_prev <= i_snooze_btn;
      end
   end

   assign o_buzzer      = (r_state == StRing);
   assign o_active_idx  = r_active_idx;
   assign o_state       = r_state;
   assign o_snooze_left = r_snooze_left;
   assign o_wr_err      = r_wr_err;

endmodule
